id_ex_seg_reg: RTL and testbench

- ID→EX pipeline segment register for the RV32I pipeline core.
- Captures decoder control outputs (RegWrite, MemToReg, MemWrite, LoadNpc, RegRead, BranchType, AluContrl, AluSrc1/2, Jalr), register-file operands, immediate, PC and register indices each cycle.
- Detects load-use hazards against the instruction already in EX and inserts a bubble.
- Exports a stall request to the IF/ID side and a valid flag.

---
 rtl/id_ex_seg_reg_pkg.sv | 63 ++++++
 rtl/id_ex_seg_reg_load_use_detect.sv | 33 +++
 rtl/id_ex_seg_reg.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_seg_reg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_seg_reg_pkg.sv
// id_ex_seg_reg_pkg: shared encodings for the RV32I ID->EX segment register.
//   - RegWrite modes, BranchType codes, ALU ops, AluSrc2 selects
//   - ctrl_t: decoder control bundle carried from ID to EX
//   - NOP_CTRL: the all-zero control bundle loaded on a bubble
//   - ST_EMPTY / ST_FULL: stage occupancy states (carried by valid_e)
package id_ex_seg_reg_pkg;

  // RegWrite modes (3 bits). Zero means the instruction writes no register.
  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  // BranchType codes (3 bits).
  localparam logic [2:0] NOBRANCH = 3'd0;
  localparam logic [2:0] BEQ      = 3'd1;
  localparam logic [2:0] BNE      = 3'd2;
  localparam logic [2:0] BLT      = 3'd3;
  localparam logic [2:0] BLTU     = 3'd4;
  localparam logic [2:0] BGE      = 3'd5;
  localparam logic [2:0] BGEU     = 3'd6;

  // ALU ops (4 bits). ADD is zero so a cleared bundle is an ADD.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // AluSrc2 selects (2 bits).
  localparam logic [1:0] SRC2_REG   = 2'd0;
  localparam logic [1:0] SRC2_SHAMT = 2'd1;
  localparam logic [1:0] SRC2_IMM   = 2'd2;

  // Stage occupancy; the state register is valid_e itself.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef struct packed {
    logic [2:0] reg_write;
    logic       mem_to_reg;
    logic [3:0] mem_write;
    logic       load_npc;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic       jalr;
  } ctrl_t;

  // No reg write, no mem write, NOBRANCH, ADD.
  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_seg_reg_load_use_detect.sv
// id_ex_seg_reg_load_use_detect: combinational load-use hazard comparator.
// Flags a dependency when EX holds a valid load with a non-x0 destination
// and the valid ID instruction reads that register through a used port.
// Ports:
//   valid_e_i, mem_to_reg_e_i, rd_e_i   - instruction currently in EX
//   valid_d_i, reg_read_d_i[1:0]        - ID instruction and its port-use bits
//   rs1_d_i, rs2_d_i                    - ID source indices
//   load_use_stall_o                    - hazard, same cycle
module id_ex_seg_reg_load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              valid_e_i,
  input  logic              mem_to_reg_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic              valid_d_i,
  input  logic [1:0]        reg_read_d_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  output logic              load_use_stall_o
);

  logic e_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load into x0 can never be a dependency.
  assign e_is_load = valid_e_i & mem_to_reg_e_i & (rd_e_i != '0);
  assign rs1_hit   = reg_read_d_i[1] & (rs1_d_i == rd_e_i);
  assign rs2_hit   = reg_read_d_i[0] & (rs2_d_i == rd_e_i);

  assign load_use_stall_o = e_is_load & valid_d_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_seg_reg.sv
// id_ex_seg_reg: ID->EX pipeline segment register for the RV32I core.
// Captures decoder controls, operands, immediate, PC and register indices,
// and inserts a bubble on a load-use hazard or a flush.
// Update priority each rising edge: clear -> bubble; en=0 -> hold;
// load_use_stall -> bubble; else capture (valid_e <= valid_d).
// Stage state is EMPTY/FULL, visible directly as valid_e.
// Ports:
//   clk, rst_n (async, active-low), en (advance), clear (sync flush)
//   *_d  inputs from ID; *_e registered outputs to EX
//   valid_e         - EX holds a real instruction
//   load_use_stall  - combinational request for IF/ID to hold
// Optional: define IDEX_PERF_CNT_EN to add bubble_cnt / stall_cnt outputs.
module id_ex_seg_reg
  import id_ex_seg_reg_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   rs1_val_d,
  input  logic [XLEN-1:0]   rs2_val_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [2:0]        reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              load_npc_d,
  input  logic              jalr_d,
  input  logic              alu_src1_d,
  input  logic [3:0]        mem_write_d,
  input  logic [1:0]        reg_read_d,
  input  logic [2:0]        branch_type_d,
  input  logic [3:0]        alu_ctrl_d,
  input  logic [1:0]        alu_src2_d,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   rs1_val_e,
  output logic [XLEN-1:0]   rs2_val_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [2:0]        reg_write_e,
  output logic              mem_to_reg_e,
  output logic              load_npc_e,
  output logic              jalr_e,
  output logic              alu_src1_e,
  output logic [3:0]        mem_write_e,
  output logic [1:0]        reg_read_e,
  output logic [2:0]        branch_type_e,
  output logic [3:0]        alu_ctrl_e,
  output logic [1:0]        alu_src2_e,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              valid_e,
  output logic              load_use_stall
);

  ctrl_t             ctrl_in;
  ctrl_t             ex_ctrl_q,    ex_ctrl_d;
  logic              ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
  logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
  logic [XLEN-1:0]   ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]   ex_rs2_val_q, ex_rs2_val_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [REG_AW-1:0] ex_rs1_q,     ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,     ex_rs2_d;
  logic              load_bubble;

  assign ctrl_in = '{reg_write:   reg_write_d,
                     mem_to_reg:  mem_to_reg_d,
                     mem_write:   mem_write_d,
                     load_npc:    load_npc_d,
                     reg_read:    reg_read_d,
                     branch_type: branch_type_d,
                     alu_ctrl:    alu_ctrl_d,
                     alu_src1:    alu_src1_d,
                     alu_src2:    alu_src2_d,
                     jalr:        jalr_d};

  id_ex_seg_reg_load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .valid_e_i        (ex_valid_q),
    .mem_to_reg_e_i   (ex_ctrl_q.mem_to_reg),
    .rd_e_i           (ex_rd_q),
    .valid_d_i        (valid_d),
    .reg_read_d_i     (reg_read_d),
    .rs1_d_i          (rs1_d),
    .rs2_d_i          (rs2_d),
    .load_use_stall_o (load_use_stall)
  );

  // clear beats the external hold; a load-use bubble waits for en.
  assign load_bubble = clear | (en & load_use_stall);

  always_comb begin
    ex_ctrl_d    = ex_ctrl_q;
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_rd_d      = ex_rd_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    if (load_bubble) begin
      ex_ctrl_d    = NOP_CTRL;
      ex_valid_d   = ST_EMPTY;
      ex_pc_d      = '0;
      ex_imm_d     = '0;
      ex_rs1_val_d = '0;
      ex_rs2_val_d = '0;
      ex_rd_d      = '0;
      ex_rs1_d     = '0;
      ex_rs2_d     = '0;
    end else if (en) begin
      // A non-valid ID slot is captured as-is; only valid_e marks it empty.
      ex_ctrl_d    = ctrl_in;
      ex_valid_d   = valid_d ? ST_FULL : ST_EMPTY;
      ex_pc_d      = pc_d;
      ex_imm_d     = imm_d;
      ex_rs1_val_d = rs1_val_d;
      ex_rs2_val_d = rs2_val_d;
      ex_rd_d      = rd_d;
      ex_rs1_d     = rs1_d;
      ex_rs2_d     = rs2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q    <= NOP_CTRL;
      ex_valid_q   <= ST_EMPTY;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  // Both counters wrap naturally modulo 2^32.
  assign bubble_cnt_d = bubble_cnt_q + {31'd0, load_bubble};
  assign stall_cnt_d  = stall_cnt_q + {31'd0, (load_use_stall & en)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

  assign valid_e       = ex_valid_q;
  assign pc_e          = ex_pc_q;
  assign imm_e         = ex_imm_q;
  assign rs1_val_e     = ex_rs1_val_q;
  assign rs2_val_e     = ex_rs2_val_q;
  assign rd_e          = ex_rd_q;
  assign rs1_e         = ex_rs1_q;
  assign rs2_e         = ex_rs2_q;
  assign reg_write_e   = ex_ctrl_q.reg_write;
  assign mem_to_reg_e  = ex_ctrl_q.mem_to_reg;
  assign mem_write_e   = ex_ctrl_q.mem_write;
  assign load_npc_e    = ex_ctrl_q.load_npc;
  assign reg_read_e    = ex_ctrl_q.reg_read;
  assign branch_type_e = ex_ctrl_q.branch_type;
  assign alu_ctrl_e    = ex_ctrl_q.alu_ctrl;
  assign alu_src1_e    = ex_ctrl_q.alu_src1;
  assign alu_src2_e    = ex_ctrl_q.alu_src2;
  assign jalr_e        = ex_ctrl_q.jalr;

endmodule

// File: tb/tb_id_ex_seg_reg.sv
// tb_id_ex_seg_reg: directed bench for the ID->EX segment register.
module tb_id_ex_seg_reg;
  import id_ex_seg_reg_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en, clear, valid_d;
  logic [XLEN-1:0]   pc_d, imm_d, rs1_val_d, rs2_val_d;
  logic [REG_AW-1:0] rd_d, rs1_d, rs2_d;
  logic [2:0]        reg_write_d, branch_type_d;
  logic              mem_to_reg_d, load_npc_d, jalr_d, alu_src1_d;
  logic [3:0]        mem_write_d, alu_ctrl_d;
  logic [1:0]        reg_read_d, alu_src2_d;

  logic [XLEN-1:0]   pc_e, imm_e, rs1_val_e, rs2_val_e;
  logic [REG_AW-1:0] rd_e, rs1_e, rs2_e;
  logic [2:0]        reg_write_e, branch_type_e;
  logic              mem_to_reg_e, load_npc_e, jalr_e, alu_src1_e;
  logic [3:0]        mem_write_e, alu_ctrl_e;
  logic [1:0]        reg_read_e, alu_src2_e;
  logic              valid_e, load_use_stall;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]       bubble_cnt, stall_cnt;
`endif

  id_ex_seg_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .valid_d(valid_d),
    .pc_d(pc_d), .imm_d(imm_d), .rs1_val_d(rs1_val_d), .rs2_val_d(rs2_val_d),
    .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
    .load_npc_d(load_npc_d), .jalr_d(jalr_d), .alu_src1_d(alu_src1_d),
    .mem_write_d(mem_write_d), .reg_read_d(reg_read_d),
    .branch_type_d(branch_type_d), .alu_ctrl_d(alu_ctrl_d),
    .alu_src2_d(alu_src2_d),
    .pc_e(pc_e), .imm_e(imm_e), .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e),
    .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .load_npc_e(load_npc_e), .jalr_e(jalr_e), .alu_src1_e(alu_src1_e),
    .mem_write_e(mem_write_e), .reg_read_e(reg_read_e),
    .branch_type_e(branch_type_e), .alu_ctrl_e(alu_ctrl_e),
    .alu_src2_e(alu_src2_e),
`ifdef IDEX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .valid_e(valid_e), .load_use_stall(load_use_stall)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    en = 1'b1; clear = 1'b0; valid_d = 1'b0;
    pc_d = '0; imm_d = '0; rs1_val_d = '0; rs2_val_d = '0;
    rd_d = '0; rs1_d = '0; rs2_d = '0;
    reg_write_d = NOREGWRITE; mem_to_reg_d = 1'b0; load_npc_d = 1'b0;
    jalr_d = 1'b0; alu_src1_d = 1'b0; mem_write_d = 4'h0;
    reg_read_d = 2'b00; branch_type_d = NOBRANCH; alu_ctrl_d = ALU_ADD;
    alu_src2_d = SRC2_REG;
  endtask

  // lw rd, 0(x2)
  task automatic drive_load(input logic [REG_AW-1:0] rd);
    drive_nop();
    valid_d = 1'b1; mem_to_reg_d = 1'b1; reg_write_d = LW; rd_d = rd;
    rs1_d = 5'd2; reg_read_d = 2'b10; alu_src2_d = SRC2_IMM;
    pc_d = 32'h0000_0030;
  endtask

  task automatic drive_garbage();
    valid_d = 1'b1; pc_d = 32'hDEAD_BEEF; imm_d = 32'hFFFF_FFFF;
    rs1_val_d = 32'h1234_5678; rs2_val_d = 32'h8765_4321;
    rd_d = 5'd31; rs1_d = 5'd30; rs2_d = 5'd29;
    reg_write_d = 3'd7; mem_to_reg_d = 1'b1; load_npc_d = 1'b1; jalr_d = 1'b1;
    alu_src1_d = 1'b1; mem_write_d = 4'hF; reg_read_d = 2'b11;
    branch_type_d = 3'd7; alu_ctrl_d = 4'hF; alu_src2_d = 2'd3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive_nop();
    drive_garbage();
    // Reset held from time 0 with garbage inputs.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid_e", valid_e, 1'b0);
    check_eq("rst_pc_e", pc_e, 32'h0);
    check_eq("rst_reg_write_e", reg_write_e, NOREGWRITE);
    check_eq("rst_mem_write_e", mem_write_e, 4'h0);
    check_eq("rst_stall", load_use_stall, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    drive_nop();
    valid_d = 1'b1; alu_ctrl_d = ALU_ADD; rd_d = 5'd5;
    step();
    check_eq("post_rst_rd_e", rd_e, 5'd5);
    check_eq("post_rst_valid_e", valid_e, 1'b1);

    // Asynchronous reset between edges clears a full stage at once.
    drive_garbage();
    step();
    check_eq("garbage_pc_e", pc_e, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pc_e", pc_e, 32'h0);
    check_eq("async_rst_valid_e", valid_e, 1'b0);
    check_eq("async_rst_alu_ctrl_e", alu_ctrl_e, ALU_ADD);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs2: lw x6 then add x7, x5, x6.
    drive_load(5'd6);
    step();
    check_eq("lw_mem_to_reg_e", mem_to_reg_e, 1'b1);
    check_eq("lw_rd_e", rd_e, 5'd6);
    drive_nop();
    valid_d = 1'b1; reg_write_d = LW; rd_d = 5'd7; rs1_d = 5'd5; rs2_d = 5'd6;
    reg_read_d = 2'b11; pc_d = 32'h0000_0040;
    #1;
    check_eq("lu_stall_asserted", load_use_stall, 1'b1);
    step();
    check_eq("lu_bubble_valid_e", valid_e, 1'b0);
    check_eq("lu_bubble_reg_write_e", reg_write_e, NOREGWRITE);
    check_eq("lu_bubble_pc_e", pc_e, 32'h0);
    check_eq("lu_stall_dropped", load_use_stall, 1'b0);
    step();
    check_eq("lu_add_valid_e", valid_e, 1'b1);
    check_eq("lu_add_rd_e", rd_e, 5'd7);
    check_eq("lu_add_pc_e", pc_e, 32'h0000_0040);

    // Load into x0 never stalls.
    drive_load(5'd0);
    step();
    drive_nop();
    valid_d = 1'b1; rs1_d = 5'd0; rs2_d = 5'd0; reg_read_d = 2'b11;
    rd_d = 5'd4; pc_d = 32'h0000_0048;
    #1;
    check_eq("x0_no_stall", load_use_stall, 1'b0);
    step();
    check_eq("x0_capture_pc_e", pc_e, 32'h0000_0048);

    // lui reads no registers: no stall even with rs1 matching.
    drive_load(5'd6);
    step();
    drive_nop();
    valid_d = 1'b1; reg_read_d = 2'b00; rs1_d = 5'd6; rd_d = 5'd8;
    imm_d = 32'h1234_5000; alu_ctrl_d = ALU_LUI; alu_src2_d = SRC2_IMM;
    pc_d = 32'h0000_0050; reg_write_d = LW;
    #1;
    check_eq("lui_no_stall", load_use_stall, 1'b0);
    step();
    check_eq("lui_imm_e", imm_e, 32'h1234_5000);
    check_eq("lui_valid_e", valid_e, 1'b1);

    // clear beats en=0 and a pending load-use.
    drive_load(5'd6);
    step();
    drive_nop();
    valid_d = 1'b1; rs1_d = 5'd6; reg_read_d = 2'b10; mem_write_d = 4'hF;
    pc_d = 32'h0000_0060;
    en = 1'b0; clear = 1'b1;
    #1;
    check_eq("clr_stall_still_high", load_use_stall, 1'b1);
    step();
    check_eq("clr_valid_e", valid_e, 1'b0);
    check_eq("clr_mem_write_e", mem_write_e, 4'h0);
    check_eq("clr_mem_to_reg_e", mem_to_reg_e, 1'b0);
    clear = 1'b0;

    // Hold for three cycles with changing D inputs.
    drive_nop();
    valid_d = 1'b1; pc_d = 32'h0000_0100; imm_d = 32'h0000_0ABC;
    rs1_val_d = 32'h0000_DEAD; rs2_val_d = 32'h0000_BEEF;
    rd_d = 5'd9; rs1_d = 5'd10; rs2_d = 5'd11; reg_write_d = LH;
    alu_ctrl_d = ALU_SLT; branch_type_d = BNE; jalr_d = 1'b1;
    load_npc_d = 1'b1; alu_src1_d = 1'b1; alu_src2_d = SRC2_SHAMT;
    reg_read_d = 2'b01; mem_write_d = 4'b0011;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_d = 32'h0000_0200 + i; rd_d = 5'd12 + 5'(i); alu_ctrl_d = ALU_XOR;
      valid_d = i[0];
      step();
      check_eq("hold_pc_e", pc_e, 32'h0000_0100);
      check_eq("hold_alu_ctrl_e", alu_ctrl_e, ALU_SLT);
    end
    check_eq("hold_imm_e", imm_e, 32'h0000_0ABC);
    check_eq("hold_rs1_val_e", rs1_val_e, 32'h0000_DEAD);
    check_eq("hold_rs2_val_e", rs2_val_e, 32'h0000_BEEF);
    check_eq("hold_rd_e", rd_e, 5'd9);
    check_eq("hold_rs1_e", rs1_e, 5'd10);
    check_eq("hold_rs2_e", rs2_e, 5'd11);
    check_eq("hold_reg_write_e", reg_write_e, LH);
    check_eq("hold_branch_type_e", branch_type_e, BNE);
    check_eq("hold_jalr_e", jalr_e, 1'b1);
    check_eq("hold_load_npc_e", load_npc_e, 1'b1);
    check_eq("hold_alu_src1_e", alu_src1_e, 1'b1);
    check_eq("hold_alu_src2_e", alu_src2_e, SRC2_SHAMT);
    check_eq("hold_reg_read_e", reg_read_e, 2'b01);
    check_eq("hold_mem_write_e", mem_write_e, 4'b0011);
    check_eq("hold_valid_e", valid_e, 1'b1);

    // en=0 defers a load-use bubble until en returns.
    en = 1'b1;
    drive_load(5'd6);
    step();
    drive_nop();
    valid_d = 1'b1; rs2_d = 5'd6; reg_read_d = 2'b01; rd_d = 5'd13;
    pc_d = 32'h0000_0070; en = 1'b0;
    step();
    check_eq("defer_hold_valid_e", valid_e, 1'b1);
    check_eq("defer_hold_mem_to_reg_e", mem_to_reg_e, 1'b1);
    check_eq("defer_stall_high", load_use_stall, 1'b1);
    en = 1'b1;
    step();
    check_eq("defer_bubble_valid_e", valid_e, 1'b0);
    step();
    check_eq("defer_capture_pc_e", pc_e, 32'h0000_0070);

    // valid_d=0 passes controls through unmodified.
    drive_nop();
    valid_d = 1'b0; reg_write_d = LW; mem_write_d = 4'b0011; rd_d = 5'd3;
    step();
    check_eq("inv_valid_e", valid_e, 1'b0);
    check_eq("inv_mem_write_e", mem_write_e, 4'b0011);
    check_eq("inv_reg_write_e", reg_write_e, LW);

    // Reset during an active load-use condition.
    drive_load(5'd6);
    step();
    drive_nop();
    valid_d = 1'b1; rs1_d = 5'd6; reg_read_d = 2'b10;
    #1;
    check_eq("rst_mid_stall_pre", load_use_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stall_drop", load_use_stall, 1'b0);
    check_eq("rst_mid_stall_valid_e", valid_e, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
